lmul_fp_pipe: RTL and testbench



---
 rtl/lmul_pkg.sv | 33 +++
 rtl/lmul_fp_pipe_if.sv | 28 ++
 rtl/lmul_lane.sv | 78 +++++++
 rtl/lmul_fp_pipe.sv | 122 ++++++++++++
 tb/tb_lmul_fp_pipe.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lmul_pkg.sv
// rtl/lmul_pkg.sv - shared constants, class encoding and format helpers for the L-Mul pipeline
package lmul_pkg;

    localparam int NAN_B = 2;
    localparam int OVF_B = 1;
    localparam int UNF_B = 0;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    // Offset exponent l shrinks for narrow mantissas so OFF never exceeds the field.
    function automatic int lmul_l(input int man_w);
        if (man_w <= 3)
            return man_w;
        else if (man_w == 4)
            return 3;
        else
            return 4;
    endfunction

    function automatic int lmul_off(input int man_w);
        return 1 << (man_w - lmul_l(man_w));
    endfunction

    function automatic int lmul_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/lmul_fp_pipe_if.sv
// rtl/lmul_fp_pipe_if.sv - operand/result handshake bundle for lmul_fp_pipe
interface lmul_fp_pipe_if #(
    parameter int LANES = 2,
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic                 i_valid;
    logic                 i_ready;
    logic [LANES*W-1:0]   i_a;
    logic [LANES*W-1:0]   i_b;
    logic                 o_valid;
    logic                 o_ready;
    logic [LANES*W-1:0]   o_p;
    logic [LANES*3-1:0]   o_flags;

    modport master (
        output i_valid, i_a, i_b, o_ready,
        input  i_ready, o_valid, o_p, o_flags
    );

    modport slave (
        input  i_valid, i_a, i_b, o_ready,
        output i_ready, o_valid, o_p, o_flags
    );

endinterface

// File: rtl/lmul_lane.sv
// rtl/lmul_lane.sv - one lane of L-Mul: stage-1 exponent/mantissa sums, stage-2 normalise and special cases
module lmul_lane
    import lmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   s1_sign,
    output logic signed [EXP_W+1:0] s1_exp,
    output logic [MAN_W:0]         s1_sum,
    output cls_e                   s1_cls_a,
    output cls_e                   s1_cls_b,
    input  logic                   s2_sign,
    input  logic signed [EXP_W+1:0] s2_exp,
    input  logic [MAN_W:0]         s2_sum,
    input  cls_e                   s2_cls_a,
    input  cls_e                   s2_cls_b,
    output logic [EXP_W+MAN_W:0]   p,
    output logic [2:0]             flags
);
    localparam logic signed [EXP_W+1:0] BIAS_S  = (EXP_W+2)'(lmul_bias(EXP_W));
    localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] ONE_S   = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] ZERO_S  = '0;
    localparam logic [MAN_W:0]          OFF_V   = (MAN_W+1)'(lmul_off(MAN_W));

    // Denormals (exponent 0) are treated as zero.
    function automatic cls_e classify(input logic [EXP_W+MAN_W:0] x);
        if (x[MAN_W +: EXP_W] == '0)
            return CLS_ZERO;
        else if (x[MAN_W +: EXP_W] == '1)
            return (x[MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
        else
            return CLS_NORM;
    endfunction

    assign s1_sign  = a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
    assign s1_exp   = $signed({2'b00, a[MAN_W +: EXP_W]}) + $signed({2'b00, b[MAN_W +: EXP_W]}) - BIAS_S;
    assign s1_sum   = {1'b0, a[MAN_W-1:0]} + {1'b0, b[MAN_W-1:0]} + OFF_V;
    assign s1_cls_a = classify(a);
    assign s1_cls_b = classify(b);

    logic signed [EXP_W+1:0] e_adj;
    logic [MAN_W-1:0]        man;

    always_comb begin
        e_adj = s2_exp;
        man   = s2_sum[MAN_W-1:0];
        if (s2_sum[MAN_W]) begin
            man   = {1'b0, s2_sum[MAN_W-1:1]};
            e_adj = s2_exp + ONE_S;
        end
    end

    always_comb begin
        p     = {s2_sign, e_adj[EXP_W-1:0], man};
        flags = '0;
        if (s2_cls_a == CLS_NAN || s2_cls_b == CLS_NAN ||
            (s2_cls_a == CLS_INF && s2_cls_b == CLS_ZERO) ||
            (s2_cls_a == CLS_ZERO && s2_cls_b == CLS_INF)) begin
            p            = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags[NAN_B] = 1'b1;
        end else if (s2_cls_a == CLS_INF || s2_cls_b == CLS_INF) begin
            p = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_cls_a == CLS_ZERO || s2_cls_b == CLS_ZERO) begin
            p = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
        end else if (e_adj >= EXP_MAX) begin
            p            = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags[OVF_B] = 1'b1;
        end else if (e_adj <= ZERO_S) begin
            p            = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
            flags[UNF_B] = 1'b1;
        end
    end

endmodule

// File: rtl/lmul_fp_pipe.sv
// rtl/lmul_fp_pipe.sv - multi-lane 2-stage L-Mul pipeline; LMUL_PIPE_STATS_EN adds op/overflow counters
module lmul_fp_pipe
    import lmul_pkg::*;
#(
    parameter int LANES = 2,
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    lmul_fp_pipe_if.slave       bus
`ifdef LMUL_PIPE_STATS_EN
    ,
    output logic [31:0]         o_stat_ops,
    output logic [31:0]         o_stat_ovf
`endif
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic v1, v2, s1_adv, s2_adv;

    logic                    c_sign [LANES];
    logic signed [EXP_W+1:0] c_exp  [LANES];
    logic [MAN_W:0]          c_sum  [LANES];
    cls_e                    c_ca   [LANES];
    cls_e                    c_cb   [LANES];

    logic                    r_sign [LANES];
    logic signed [EXP_W+1:0] r_exp  [LANES];
    logic [MAN_W:0]          r_sum  [LANES];
    cls_e                    r_ca   [LANES];
    cls_e                    r_cb   [LANES];

    logic [LANES*W-1:0] p_c, p_q;
    logic [LANES*3-1:0] flags_c, flags_q;

    assign s2_adv      = !v2 || bus.o_ready;
    assign s1_adv      = !v1 || s2_adv;
    assign bus.i_ready = s1_adv;
    assign bus.o_valid = v2;
    assign bus.o_p     = p_q;
    assign bus.o_flags = flags_q;

    for (genvar k = 0; k < LANES; k++) begin : gen_lane
        lmul_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_lane (
            .a        (bus.i_a[k*W +: W]),
            .b        (bus.i_b[k*W +: W]),
            .s1_sign  (c_sign[k]),
            .s1_exp   (c_exp[k]),
            .s1_sum   (c_sum[k]),
            .s1_cls_a (c_ca[k]),
            .s1_cls_b (c_cb[k]),
            .s2_sign  (r_sign[k]),
            .s2_exp   (r_exp[k]),
            .s2_sum   (r_sum[k]),
            .s2_cls_a (r_ca[k]),
            .s2_cls_b (r_cb[k]),
            .p        (p_c[k*W +: W]),
            .flags    (flags_c[k*3 +: 3])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            p_q     <= '0;
            flags_q <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_sign[k] <= 1'b0;
                r_exp[k]  <= '0;
                r_sum[k]  <= '0;
                r_ca[k]   <= CLS_ZERO;
                r_cb[k]   <= CLS_ZERO;
            end
        end else begin
            if (s1_adv) begin
                v1 <= bus.i_valid;
                if (bus.i_valid) begin
                    for (int k = 0; k < LANES; k++) begin
                        r_sign[k] <= c_sign[k];
                        r_exp[k]  <= c_exp[k];
                        r_sum[k]  <= c_sum[k];
                        r_ca[k]   <= c_ca[k];
                        r_cb[k]   <= c_cb[k];
                    end
                end
            end
            // Output registers only move on an advance, so they hold while stalled.
            if (s2_adv) begin
                v2 <= v1;
                if (v1) begin
                    p_q     <= p_c;
                    flags_q <= flags_c;
                end
            end
        end
    end

`ifdef LMUL_PIPE_STATS_EN
    logic ovf_hit;

    always_comb begin
        ovf_hit = 1'b0;
        for (int k = 0; k < LANES; k++)
            ovf_hit = ovf_hit | flags_q[k*3 + OVF_B];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_stat_ops <= '0;
            o_stat_ovf <= '0;
        end else begin
            if (bus.i_valid && bus.i_ready && o_stat_ops != '1)
                o_stat_ops <= o_stat_ops + 32'd1;
            if (bus.o_valid && bus.o_ready && ovf_hit && o_stat_ovf != '1)
                o_stat_ovf <= o_stat_ovf + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lmul_fp_pipe.sv
// tb/tb_lmul_fp_pipe.sv - self-checking bench for lmul_fp_pipe (BF16, 2 lanes); checks counters when LMUL_PIPE_STATS_EN is defined
module tb_lmul_fp_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lmul_fp_pipe_if #(.LANES(2), .EXP_W(8), .MAN_W(7)) bus ();

`ifdef LMUL_PIPE_STATS_EN
    logic [31:0] stat_ops, stat_ovf;
`endif

    lmul_fp_pipe #(.LANES(2), .EXP_W(8), .MAN_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef LMUL_PIPE_STATS_EN
        ,
        .o_stat_ops (stat_ops),
        .o_stat_ovf (stat_ovf)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: L-Mul rules for one BF16 lane, returns {flags[2:0], p[15:0]}
    function automatic logic [18:0] lane_model(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, e, s, man;
        logic sg, za, zb, ia, ib, na, nb;
        logic [15:0] p;
        logic [2:0]  f;
        ea = int'(a[14:7]); eb = int'(b[14:7]);
        ma = int'(a[6:0]);  mb = int'(b[6:0]);
        sg = a[15] ^ b[15];
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 255 && ma == 0); ib = (eb == 255 && mb == 0);
        na = (ea == 255 && ma != 0); nb = (eb == 255 && mb != 0);
        e = ea + eb - 127;
        s = (ma + mb + 8) % 256;
        if (s >= 128) begin
            man = (s - 128) / 2;
            e   = e + 1;
        end else begin
            man = s;
        end
        f = 3'b000;
        if (na || nb || (ia && zb) || (za && ib)) begin
            p = 16'h7FC0; f = 3'b100;
        end else if (ia || ib) begin
            p = {sg, 15'h7F80};
        end else if (za || zb) begin
            p = {sg, 15'h0000};
        end else if (e >= 255) begin
            p = {sg, 15'h7F80}; f = 3'b010;
        end else if (e <= 0) begin
            p = {sg, 15'h0000}; f = 3'b001;
        end else begin
            p = {sg, 8'(e), 7'(man)};
        end
        return {f, p};
    endfunction

    function automatic logic [15:0] rnd_op();
        int sel;
        logic [7:0] e;
        sel = $urandom_range(0, 11);
        case (sel)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'h01;
            3:       e = 8'hFE;
            4:       e = 8'(40 + $urandom_range(0, 10));
            5:       e = 8'(190 + $urandom_range(0, 10));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
    endfunction

    typedef struct {
        logic [31:0] p;
        logic [5:0]  f;
        int          t;
    } exp_t;

    exp_t q[$];
    int   last_pop = -10;
    int   npops = 0;
    int   ops_m = 0;
    int   ovf_m = 0;

    // Every cycle: o_valid timing, i_ready and data checked against the queue model.
    always @(negedge clk) begin
        int   appear;
        logic exp_valid;
        logic [18:0] r0, r1;
        exp_t e;
        if (rst) begin
            q.delete();
            last_pop = -10;
            ops_m = 0;
            ovf_m = 0;
            chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
        end else begin
            exp_valid = 1'b0;
            if (q.size() > 0) begin
                appear = q[0].t + 2;
                if (last_pop + 1 > appear) appear = last_pop + 1;
                exp_valid = (cyc >= appear);
            end
            chk("o_valid", 64'(bus.o_valid), 64'(exp_valid));
            chk("i_ready", 64'(bus.i_ready), 64'(!(q.size() == 2 && !bus.o_ready)));
            if (bus.o_valid && exp_valid) begin
                chk("o_p", 64'(bus.o_p), 64'(q[0].p));
                chk("o_flags", 64'(bus.o_flags), 64'(q[0].f));
                if (bus.o_ready) begin
                    if (q[0].f[1] || q[0].f[4]) ovf_m++;
                    void'(q.pop_front());
                    last_pop = cyc;
                    npops++;
                end
            end
            if (bus.i_valid && bus.i_ready) begin
                r0 = lane_model(bus.i_a[15:0], bus.i_b[15:0]);
                r1 = lane_model(bus.i_a[31:16], bus.i_b[31:16]);
                e.p = {r1[15:0], r0[15:0]};
                e.f = {r1[18:16], r0[18:16]};
                e.t = cyc;
                q.push_back(e);
                ops_m++;
            end
        end
    end

    task automatic send1(input logic [31:0] a, input logic [31:0] b);
        logic ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.i_valid = 1'b1; bus.i_a = a; bus.i_b = b; bus.o_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.i_ready) begin ok = 1'b1; break; end
        end
        chk("send_accept", 64'(ok), 64'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && q.size() > 0; n++) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic pin(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ep, input logic [5:0] ef);
        logic [18:0] r0, r1;
        r0 = lane_model(a[15:0], b[15:0]);
        r1 = lane_model(a[31:16], b[31:16]);
        chk("model_p", 64'({r1[15:0], r0[15:0]}), 64'(ep));
        chk("model_f", 64'({r1[18:16], r0[18:16]}), 64'(ef));
        send1(a, b);
        drain();
    endtask

    task automatic lat_test();
        @(posedge clk); #1;
        bus.i_valid = 1'b1; bus.o_ready = 1'b1;
        bus.i_a = 32'h3FC0_3F80; bus.i_b = 32'h3FC0_3F80;
        @(negedge clk);
        chk("lat_ready", 64'(bus.i_ready), 64'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("lat_t1_valid", 64'(bus.o_valid), 64'd0);
        @(negedge clk);
        chk("lat_t2_valid", 64'(bus.o_valid), 64'd1);
        chk("lat_t2_p", 64'(bus.o_p), 64'h4004_3F88);
        chk("lat_t2_flags", 64'(bus.o_flags), 64'd0);
        drain();
    endtask

    task automatic stream(input int n, input int vprob, input int rprob,
                          input int stall_lo, input int stall_hi);
        int idx, budget, pops0;
        logic [31:0] a, b;
        idx = 0; budget = 0; pops0 = npops;
        a = {rnd_op(), rnd_op()}; b = {rnd_op(), rnd_op()};
        while ((idx < n || q.size() > 0) && budget < 3000) begin
            @(posedge clk); #1;
            bus.i_valid = (idx < n) && ($urandom_range(0, 99) < vprob);
            bus.i_a = a; bus.i_b = b;
            bus.o_ready = !(budget >= stall_lo && budget < stall_hi) &&
                          ($urandom_range(0, 99) < rprob);
            @(negedge clk);
            if (bus.i_valid && bus.i_ready) begin
                idx++;
                a = {rnd_op(), rnd_op()}; b = {rnd_op(), rnd_op()};
            end
            budget++;
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.o_ready = 1'b1;
        chk("stream_sent", 64'(idx), 64'(n));
        chk("stream_emitted", 64'(npops - pops0), 64'(n));
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.o_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_o_p", 64'(bus.o_p), 64'd0);
        chk("reset_o_flags", 64'(bus.o_flags), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_i_ready", 64'(bus.i_ready), 64'd1);

        lat_test();
        pin(32'h0080_7F00, 32'h0080_7F00, 32'h0000_7F80, 6'b001_010);
        pin(32'h7F80_8000, 32'h0000_3F80, 32'h7FC0_8000, 6'b100_000);
        pin(32'h3F80_FF80, 32'h3F80_3F80, 32'h3F88_FF80, 6'b000_000);

        stream(10, 100, 100, 4, 9);
        stream(300, 70, 70, 0, 0);
        stream(100, 100, 100, 0, 0);

        // Reset while both stages hold data.
        @(posedge clk); #1;
        bus.o_ready = 1'b0; bus.i_valid = 1'b1;
        bus.i_a = {rnd_op(), rnd_op()}; bus.i_b = {rnd_op(), rnd_op()};
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!bus.i_ready) break;
        end
        chk("rst_mid_full", 64'(bus.i_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_o_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_mid_o_p", 64'(bus.o_p), 64'd0);
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.o_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(bus.o_valid), 64'd0);
        end
        lat_test();

`ifdef LMUL_PIPE_STATS_EN
        chk("stat_ops_model", 64'(stat_ops), 64'(ops_m));
        chk("stat_ovf_model", 64'(stat_ovf), 64'(ovf_m));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) send1(32'h3F80_3FC0, 32'h3F80_3FC0);
        send1(32'h3F80_7F00, 32'h3F80_7F00);
        drain();
        @(negedge clk);
        chk("stat_ops", 64'(stat_ops), 64'd4);
        chk("stat_ovf", 64'(stat_ovf), 64'd1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
